// File: rtl/fetcher_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetcher_pkg;

    typedef logic [31:0] addr_t;   // ADDR_TYPE
    typedef logic [31:0] inst_t;   // INS_TYPE

    // Opcode field of a 32-bit instruction (OPCODE_RANGE)
    localparam int OPCODE_MSB = 6;
    localparam int OPCODE_LSB = 0;

    // Fetch FSM encodings
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    // Sequential PC increment
    localparam addr_t PC_INC = 32'd4;

endpackage

// File: rtl/fetcher_icache.sv
// Direct-mapped instruction cache: combinational lookup, single-port fill,
// valid bits cleared by the asynchronous active-low reset.
module fetcher_icache
    import fetcher_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    input  addr_t lookup_pc,
    output logic  lookup_hit,
    output inst_t lookup_inst,
    input  logic  fill_valid,
    input  addr_t fill_addr,
    input  inst_t fill_inst
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 32 - IDX_W - 2;

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    inst_t            data_q [LINES];

    logic [IDX_W-1:0] lk_idx, fl_idx;
    logic [TAG_W-1:0] lk_tag, fl_tag;
    logic             unused_offset;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[31:IDX_W+2];
    assign fl_idx = fill_addr[IDX_W+1:2];
    assign fl_tag = fill_addr[31:IDX_W+2];
    // Byte offset bits are meaningless for word-aligned fetches
    assign unused_offset = ^{lookup_pc[1:0], fill_addr[1:0]};

    assign lookup_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lookup_inst = data_q[lk_idx];

    // Next valid vector: set the filled line
    always_comb begin
        valid_d = valid_q;
        if (fill_valid) valid_d[fl_idx] = 1'b1;
    end

    // Valid bits are the only state that needs clearing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    // Tag/data storage, written on fill only
    always_ff @(posedge clk) begin
        if (fill_valid) begin
            tag_q[fl_idx]  <= fl_tag;
            data_q[fl_idx] <= fill_inst;
        end
    end

endmodule

// File: rtl/fetcher.sv
// Instruction-fetch stage: PC, one outstanding memory fetch, optional
// direct-mapped I-cache (macro ICACHE_EN), predictor query, issue handshake,
// and ROB flush redirect with stale-response draining.
module fetcher
    import fetcher_pkg::*;
#(
    parameter addr_t RESET_PC     = 32'h0,
    parameter int    ICACHE_LINES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_inst,
    output logic [31:0] pred_query_pc,
    output logic [31:0] pred_query_inst,
    input  logic        pred_jump,
    input  logic [31:0] pred_target,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [31:0] issue_inst,
    output logic [31:0] issue_pc,
    output logic        issue_pred_jump,
    output logic [31:0] issue_pred_target,
    input  logic        flush_valid,
    input  logic [31:0] flush_pc
);

    fetch_state_e state_q, state_d;
    addr_t        pc_q, pc_d;
    addr_t        hold_pc_q, hold_pc_d;
    inst_t        hold_inst_q, hold_inst_d;

    logic  cache_hit;
    inst_t cache_inst;
    logic  cache_fill;
    addr_t next_pc;

`ifdef ICACHE_EN
    fetcher_icache #(.LINES(ICACHE_LINES)) u_icache (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_pc   (pc_q),
        .lookup_hit  (cache_hit),
        .lookup_inst (cache_inst),
        .fill_valid  (cache_fill),
        .fill_addr   (pc_q),
        .fill_inst   (mem_resp_inst)
    );
`else
    localparam int unused_lines = ICACHE_LINES;
    logic unused_fill;
    assign cache_hit   = 1'b0;
    assign cache_inst  = '0;
    assign unused_fill = cache_fill;
`endif

    // Predicted successor of the held instruction
    assign next_pc = pred_jump ? pred_target : hold_pc_q + PC_INC;

    assign mem_req_valid     = (state_q == ST_WAIT);
    assign mem_req_addr      = mem_req_valid ? pc_q : '0;
    assign pred_query_pc     = hold_pc_q;
    assign pred_query_inst   = hold_inst_q;
    assign issue_valid       = (state_q == ST_HOLD) && !flush_valid;
    assign issue_inst        = hold_inst_q;
    assign issue_pc          = hold_pc_q;
    assign issue_pred_jump   = pred_jump;
    assign issue_pred_target = next_pc;

    // Next-state logic; flush wins over everything, rdy=0 freezes all state
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_pc_d   = hold_pc_q;
        hold_inst_d = hold_inst_q;
        cache_fill  = 1'b0;
        if (rdy) begin
            if (flush_valid) begin
                pc_d = flush_pc;
                // A request still outstanding must have its response swallowed
                if ((state_q == ST_WAIT || state_q == ST_DRAIN) && !mem_resp_valid)
                    state_d = ST_DRAIN;
                else
                    state_d = ST_FETCH;
            end else begin
                unique case (state_q)
                    ST_FETCH: begin
                        if (cache_hit) begin
                            hold_inst_d = cache_inst;
                            hold_pc_d   = pc_q;
                            state_d     = ST_HOLD;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (mem_resp_valid) begin
                            hold_inst_d = mem_resp_inst;
                            hold_pc_d   = pc_q;
                            cache_fill  = 1'b1;
                            state_d     = ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (issue_ready) begin
                            pc_d    = next_pc;
                            state_d = ST_FETCH;
                        end
                    end
                    ST_DRAIN: begin
                        if (mem_resp_valid) state_d = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
        end
    end

    // Fetch FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            hold_pc_q   <= '0;
            hold_inst_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_pc_q   <= hold_pc_d;
            hold_inst_q <= hold_inst_d;
        end
    end

endmodule

// File: tb/tb_fetcher.sv
// Scoreboard bench for fetcher: stimulus pushes expected issues and memory
// request addresses; negedge monitors pop and compare. Build with ICACHE_EN
// defined to exercise the cache-hit expectations.
module tb_fetcher;
    import fetcher_pkg::*;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ADDI   = 32'h0010_0093;
    localparam logic [31:0] JAL40  = 32'h0400_006f;  // +0x40
    localparam logic [31:0] JALC0  = 32'h0c00_006f;  // +0xC0
    localparam logic [31:0] JALM8  = 32'hff9f_f06f;  // -8

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        jump;
        logic [31:0] tgt;
    } iss_t;

    logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b1;
    logic        mem_req_valid, mem_resp_valid = 1'b0;
    logic [31:0] mem_req_addr, mem_resp_inst = '0;
    logic [31:0] pred_query_pc, pred_query_inst, pred_target;
    logic        pred_jump;
    logic        issue_valid, issue_ready = 1'b0, issue_pred_jump;
    logic [31:0] issue_inst, issue_pc, issue_pred_target;
    logic        flush_valid = 1'b0;
    logic [31:0] flush_pc = '0;

    iss_t        exp_iss[$];
    logic [31:0] exp_req[$];
    int          n_chk = 0, n_fail = 0;
    logic        req_prev = 1'b0;

    always #5 clk = ~clk;

    fetcher #(.RESET_PC(32'h100), .ICACHE_LINES(16)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_inst(mem_resp_inst),
        .pred_query_pc(pred_query_pc), .pred_query_inst(pred_query_inst),
        .pred_jump(pred_jump), .pred_target(pred_target),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_inst(issue_inst), .issue_pc(issue_pc),
        .issue_pred_jump(issue_pred_jump), .issue_pred_target(issue_pred_target),
        .flush_valid(flush_valid), .flush_pc(flush_pc)
    );

    // Predictor model: JAL is taken to pc + J-immediate
    function automatic logic [31:0] jimm(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction
    assign pred_jump   = (pred_query_inst[OPCODE_MSB:OPCODE_LSB] == 7'h6f);
    assign pred_target = pred_query_pc + jimm(pred_query_inst);

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitors: compare every accepted issue and every new memory request
    always @(negedge clk) begin
        if (rst_n) begin
            if (rdy && issue_valid && issue_ready) begin
                if (exp_iss.size() == 0) begin
                    check("issue_unexpected_pc", issue_pc, 32'hxxxx_xxxx);
                end else begin
                    iss_t e;
                    e = exp_iss.pop_front();
                    check("issue_pc", issue_pc, e.pc);
                    check("issue_inst", issue_inst, e.inst);
                    check("issue_pred_jump", {31'b0, issue_pred_jump}, {31'b0, e.jump});
                    check("issue_pred_target", issue_pred_target, e.tgt);
                end
            end
            if (mem_req_valid && !req_prev) begin
                if (exp_req.size() == 0) check("req_unexpected_addr", mem_req_addr, 32'hxxxx_xxxx);
                else                     check("mem_req_addr", mem_req_addr, exp_req.pop_front());
            end
            req_prev <= mem_req_valid;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push_iss(input logic [31:0] pc, input logic [31:0] inst,
                            input logic jump, input logic [31:0] tgt);
        iss_t e;
        e.pc = pc; e.inst = inst; e.jump = jump; e.tgt = tgt;
        exp_iss.push_back(e);
    endtask

    task automatic expect_req(input logic [31:0] addr);
        int n = 0;
        exp_req.push_back(addr);
        while (!mem_req_valid && n < 100) begin tick(); n++; end
        check("req_wait", {31'b0, mem_req_valid}, 32'd1);
    endtask

    task automatic respond(input logic [31:0] inst, input int lat);
        tick(lat);
        mem_resp_valid = 1'b1; mem_resp_inst = inst;
        tick();
        mem_resp_valid = 1'b0; mem_resp_inst = '0;
    endtask

    task automatic serve(input logic [31:0] addr, input logic [31:0] inst, input int lat);
        expect_req(addr);
        respond(inst, lat);
    endtask

    task automatic wait_issue();
        int n = 0;
        while (!issue_valid && n < 100) begin tick(); n++; end
        check("issue_wait", {31'b0, issue_valid}, 32'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_iss.size() != 0 && n < 200) begin tick(); n++; end
        check("issue_drain", exp_iss.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(3);
        check("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check("rst_mem_req_addr", mem_req_addr, 32'd0);
        check("rst_issue_valid", {31'b0, issue_valid}, 32'd0);
        check("rst_issue_pc", issue_pc, 32'd0);
        check("rst_issue_inst", issue_inst, 32'd0);
        rst_n = 1'b1;
        issue_ready = 1'b1;

        // First miss from RESET_PC, then sequential request
        push_iss(32'h100, NOP, 1'b0, 32'h104);
        serve(32'h100, NOP, 3);
        wait_drain();
        issue_ready = 1'b0;
        serve(32'h104, NOP, 1);

        // Flush in HOLD masks issue_valid and blocks PC advance
        wait_issue();
        issue_ready = 1'b1; flush_valid = 1'b1; flush_pc = 32'h200;
        #1;
        check("flush_hold_issue_valid", {31'b0, issue_valid}, 32'd0);
        tick();
        flush_valid = 1'b0; issue_ready = 1'b0;

        // Held JAL stays stable while decode stalls
        serve(32'h200, JAL40, 2);
        for (int i = 0; i < 4; i++) begin
            check("stall_issue_valid", {31'b0, issue_valid}, 32'd1);
            check("stall_issue_pc", issue_pc, 32'h200);
            check("stall_issue_inst", issue_inst, JAL40);
            check("stall_pred_target", issue_pred_target, 32'h240);
            tick();
        end
        push_iss(32'h200, JAL40, 1'b1, 32'h240);
        push_iss(32'h240, JALC0, 1'b1, 32'h300);
        issue_ready = 1'b1;
        serve(32'h240, JALC0, 1);

        // Flush during WAIT for 0x300 -> DRAIN, stale response discarded
        expect_req(32'h300);
        tick(2);
        flush_valid = 1'b1; flush_pc = 32'h80;
        tick();
        flush_valid = 1'b0;
        check("drain_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check("drain_issue_valid", {31'b0, issue_valid}, 32'd0);
        tick(2);
        check("drain_req_valid_late", {31'b0, mem_req_valid}, 32'd0);
        respond(32'hdead_beef, 0);
        push_iss(32'h80, ADDI, 1'b0, 32'h84);
        serve(32'h80, ADDI, 2);

        // Flush coincident with a response: response dropped, back to FETCH
        expect_req(32'h84);
        tick();
        mem_resp_valid = 1'b1; mem_resp_inst = 32'h1234_5678;
        flush_valid = 1'b1; flush_pc = 32'h80;
        tick();
        mem_resp_valid = 1'b0; flush_valid = 1'b0;
        check("same_cycle_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check("same_cycle_issue_valid", {31'b0, issue_valid}, 32'd0);
        push_iss(32'h80, ADDI, 1'b0, 32'h84);
`ifndef ICACHE_EN
        serve(32'h80, ADDI, 1);
`endif
        wait_drain();
        issue_ready = 1'b0;
        serve(32'h84, NOP, 1);   // dropped response must not have been cached

        // PC wrap at the top of the address space
        wait_issue();
        flush_valid = 1'b1; flush_pc = 32'hffff_fffc;
        tick();
        flush_valid = 1'b0;
        push_iss(32'hffff_fffc, NOP, 1'b0, 32'h0);
        issue_ready = 1'b1;
        serve(32'hffff_fffc, NOP, 1);

        // rdy=0 mid-WAIT freezes the request
        expect_req(32'h0);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("frz_req_valid", {31'b0, mem_req_valid}, 32'd1);
            check("frz_req_addr", mem_req_addr, 32'h0);
        end
        rdy = 1'b1;

        // Loop 0x0 -> 0x4 -> 0x8 -> 0x0, first pass misses
        push_iss(32'h0, NOP, 1'b0, 32'h4);
        respond(NOP, 1);
        push_iss(32'h4, NOP, 1'b0, 32'h8);
        serve(32'h4, NOP, 1);
        push_iss(32'h8, JALM8, 1'b1, 32'h0);
        serve(32'h8, JALM8, 1);
        wait_drain();

        // Second pass
        push_iss(32'h0, NOP, 1'b0, 32'h4);
        push_iss(32'h4, NOP, 1'b0, 32'h8);
        push_iss(32'h8, JALM8, 1'b1, 32'h0);
`ifdef ICACHE_EN
        tick(5);
        check("hit_rate_pending", exp_iss.size(), 32'd1);
        tick();
        check("hit_rate_done", exp_iss.size(), 32'd0);
        issue_ready = 1'b0;
        tick(4);
`else
        serve(32'h0, NOP, 1);
        serve(32'h4, NOP, 1);
        serve(32'h8, JALM8, 1);
        wait_drain();
        issue_ready = 1'b0;
        expect_req(32'h0);
        tick(2);
`endif
        check("req_queue_empty", exp_req.size(), 32'd0);
        check("iss_queue_empty", exp_iss.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetcher.md
# fetcher

Instruction-fetch stage of the IF unit. Holds the PC, fetches one 32-bit instruction at a time from the memory controller (optionally via a small direct-mapped instruction cache), queries the combinational branch predictor with the fetched instruction, and hands {inst, pc, prediction} to decode over a valid/ready handshake. A ROB flush redirects the PC and discards any in-flight memory response.

## Interface
Parameters:
- RESET_PC, 32'h0, PC loaded on reset
- ICACHE_LINES, 16, cache lines (power of 2, ≥2); used only with the cache compiled in

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; low freezes all state
- mem_req_valid  out  1  fetch request pending
- mem_req_addr  out  32  word-aligned fetch address
- mem_resp_valid  in  1  one-cycle pulse, response data valid
- mem_resp_inst  in  32  fetched instruction
- pred_query_pc  out  32  PC of held instruction
- pred_query_inst  out  32  held instruction
- pred_jump  in  1  predictor: taken
- pred_target  in  32  predictor: absolute target PC
- issue_valid  out  1  instruction available to decode
- issue_ready  in  1  decode accepts
- issue_inst  out  32  instruction
- issue_pc  out  32  its PC
- issue_pred_jump  out  1  prediction forwarded to decode/ROB
- issue_pred_target  out  32  predicted next PC
- flush_valid  in  1  mispredict redirect from ROB
- flush_pc  in  32  redirect PC

## Operation
- States: FETCH, WAIT, HOLD, DRAIN. Reset: state FETCH, pc=RESET_PC, hold regs 0, all outputs 0, cache valid bits cleared.
- FETCH: cache hit at pc -> load hold reg, go HOLD. Otherwise go WAIT.
- WAIT: mem_req_valid=1, mem_req_addr=pc, held until mem_resp_valid. On response: capture inst, fill cache line, go HOLD. Controller latches the request on its first valid cycle; exactly one outstanding request.
- HOLD: issue_valid=1 (masked to 0 while flush_valid). On issue_valid&&issue_ready: pc <= pred_jump ? pred_target : pc+4 (mod 2^32, wraps), go FETCH.
- issue_pred_jump/issue_pred_target = pred_jump / (pred_jump ? pred_target : pc+4).
- flush_valid (highest priority, any state): pc <= flush_pc. From WAIT without mem_resp_valid in the same cycle -> DRAIN; otherwise -> FETCH. A same-cycle response is discarded and does not fill the cache.
- DRAIN: mem_req_valid=0; the next mem_resp_valid is discarded (no cache fill) -> FETCH. A further flush in DRAIN only updates pc.
- Cache is never invalidated by flush (no self-modifying code support).
- rdy=0: no state, pc, or cache updates; outputs hold.

## Timing
- pred_query_*, issue_inst, issue_pc driven from registers; issue_pred_* combinational through the predictor.
- Cache hit: FETCH at cycle t, issue_valid at t+1; back-to-back accepted hits issue every 2 cycles.
- Miss: mem_req_valid from t+1 until response cycle r; issue_valid at r+1.
- Flush takes effect next edge; the first request to flush_pc is no earlier than the cycle after flush (FETCH), or after the drained response.

## Configuration
- ICACHE_EN defined: direct-mapped cache, ICACHE_LINES lines, index pc[log2(ICACHE_LINES)+1:2], tag pc[31:log2(ICACHE_LINES)+2], 1 valid bit/line; fill on accepted WAIT responses only.
- Undefined: no cache storage; FETCH always goes to WAIT; ICACHE_LINES ignored.

## Structure
- Shared defines: ADDR_TYPE, INS_TYPE, OPCODE_RANGE, fetch state encodings, 32'd4 increment constant.
- Sub-module: icache (lookup port: pc -> hit, inst; fill port: valid, addr, inst; async active-low clear), instantiated only under ICACHE_EN.

## Test plan
- Reset with RESET_PC=0x100, mem returns 0x00000013 after 3 cycles, issue_ready=1 -> issue_pc=0x100, then request at 0x104.
- Held JAL at 0x200, pred_jump=1, pred_target=0x240, issue_ready=0 for 4 cycles -> issue_valid stable, outputs unchanged; on accept next mem_req_addr=0x240.
- flush_valid with flush_pc=0x80 during WAIT for 0x300 -> DRAIN; stale response discarded, not cached; next issue_pc=0x80 with the 0x80 instruction.
- Flush in the same cycle as mem_resp_valid -> response dropped, state FETCH, pc=0x80; flush in HOLD with issue_ready=1 -> issue_valid=0 that cycle, no PC advance.
- ICACHE_EN: loop 0x0->0x4->0x8 (JAL back to 0x0) twice -> second pass no mem_req_valid, issue every 2 cycles; without ICACHE_EN every fetch requests memory.
- pc=0xFFFFFFFC non-jump accepted -> next fetch address 0x00000000; rdy=0 mid-WAIT with response held off -> state and pc frozen.
